// File: rtl/itof_seq.sv
// ---------------------------------------------------------------------------
// itof_seq -- sequential signed 32-bit integer to IEEE-754 single converter.
//
// An operand is accepted over a valid/ready handshake, its magnitude is
// taken, and it is normalised one bit per cycle until the leading one sits in
// bit 31. Sign, biased exponent and mantissa are then packed into a result
// that is held until the consumer accepts it.
//
// Build option:
//   ITOF_ROUND_EN  defined   -> round to nearest, ties to even
//                  undefined -> truncate toward zero (no rounding logic)
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand valid
//   in_ready   out  1   block can accept an operand (IDLE only)
//   in_data    in   32  signed integer operand
//   out_valid  out  1   result valid, held until accepted
//   out_ready  in   1   consumer accepts result
//   out_data   out  32  IEEE-754 single-precision result
//   busy       out  1   high in any state other than IDLE
// ---------------------------------------------------------------------------
module itof_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ABS  = 3'd1;
    localparam logic [2:0] NORM = 3'd2;
    localparam logic [2:0] PACK = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state;
    logic        sign;
    logic        zero_flag;
    logic [31:0] mag;
    logic [5:0]  shift_cnt;

    // Packing datapath (combinational, consumed only in PACK).
    logic [22:0] mant_rnd;
    logic        mant_carry;
    logic [7:0]  exp_biased;
    logic [31:0] abs_val;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // In IDLE/ABS the mag register still holds the raw operand, so the
    // two's-complement negate works on it directly. 0x80000000 maps onto
    // itself, which is exactly the unsigned magnitude 2^31.
    assign abs_val = sign ? (~mag + 32'd1) : mag;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        mant_rnd   = mag[30:8];
        mant_carry = 1'b0;
`ifdef ITOF_ROUND_EN
        begin
            logic guard_bit;
            logic sticky_bit;
            guard_bit  = mag[7];
            sticky_bit = |mag[6:0];
            if (guard_bit && (sticky_bit || mag[8]))
                {mant_carry, mant_rnd} = {1'b0, mag[30:8]} + 24'd1;
        end
`endif
        // 158 = 127 bias + 31: the leading one starts at bit 31 with no shift.
        // A rounding carry leaves the mantissa at zero and bumps the exponent.
        exp_biased = 8'd158 - {2'b00, shift_cnt} + {7'd0, mant_carry};
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            zero_flag <= 1'b0;
            mag       <= 32'd0;
            shift_cnt <= 6'd0;
            out_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= in_data[31];
                        mag   <= in_data;
                        state <= ABS;
                    end
                end
                ABS: begin
                    mag       <= abs_val;
                    shift_cnt <= 6'd0;
                    zero_flag <= (abs_val == 32'd0);
                    state     <= (abs_val == 32'd0) ? PACK : NORM;
                end
                NORM: begin
                    // mag is nonzero here, so at most 31 shifts are needed.
                    if (mag[31]) begin
                        state <= PACK;
                    end else begin
                        mag       <= {mag[30:0], 1'b0};
                        shift_cnt <= shift_cnt + 6'd1;
                    end
                end
                PACK: begin
                    // Zero is always +0, even though sign is still latched.
                    if (zero_flag)
                        out_data <= 32'h0000_0000;
                    else
                        out_data <= {sign, exp_biased, mant_rnd};
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_itof_seq.sv
// ---------------------------------------------------------------------------
// tb_itof_seq -- directed self-checking bench for itof_seq.
// Inputs are driven on the falling edge, outputs sampled 1 ns after the
// rising edge. Expected values are hand-computed for each vector.
// ---------------------------------------------------------------------------
module tb_itof_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int total_cnt;
    int bad_cnt;

    itof_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until out_valid is seen after a rising edge; returns the
    // number of edges counted since the accept edge.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Present an operand on the falling edge; the next rising edge accepts it.
    task automatic accept_op(input logic [31:0] op);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic convert(input string tag, input logic [31:0] op,
                           input logic [31:0] exp_data, input int exp_lat);
        int edges;
        accept_op(op);
        wait_result(edges);
        check({tag, " latency"}, 32'(edges), 32'(exp_lat));
        check({tag, " data"}, out_data, exp_data);
        take_result();
        check({tag, " back to idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int edges;
        logic [31:0] held;
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;

        // Reset state.
        #12;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic conversions and latency extremes.
        convert("one",     32'h0000_0001, 32'h3F80_0000, 34);
        convert("minus1",  32'hFFFF_FFFF, 32'hBF80_0000, 34);
        convert("minint",  32'h8000_0000, 32'hCF00_0000, 3);
        convert("zero",    32'h0000_0000, 32'h0000_0000, 2);
        convert("three",   32'h0000_0003, 32'h4040_0000, 33);

        // Rounding behaviour.
`ifdef ITOF_ROUND_EN
        convert("maxint",  32'h7FFF_FFFF, 32'h4F00_0000, 4);
        convert("tie_odd", 32'h0100_0003, 32'h4B80_0002, 10);
`else
        convert("maxint",  32'h7FFF_FFFF, 32'h4EFF_FFFF, 4);
        convert("tie_odd", 32'h0100_0003, 32'h4B80_0001, 10);
`endif
        convert("tie_even", 32'h0100_0001, 32'h4B80_0000, 10);

        // Backpressure: 0x2 converts to 0x40000000 and is held while a new
        // operand is offered and must be ignored.
        accept_op(32'h0000_0002);
        wait_result(edges);
        check("bp latency", 32'(edges), 32'd33);
        held = out_data;
        check("bp data", held, 32'h4000_0000);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000_0005;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp hold data", out_data, held);
            check("bp hold ready", {31'd0, in_ready, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp handoff", {30'd0, in_ready, out_valid}, 32'd2);
        // in_valid is still high: the next edge accepts 0x5.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp accepted", {31'd0, busy}, 32'd1);
        wait_result(edges);
        check("bp five latency", 32'(edges), 32'd32);
        check("bp five data", out_data, 32'h40A0_0000);
        take_result();

        // Asynchronous reset mid-normalisation.
        accept_op(32'h0000_0001);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert("post rst", 32'h0000_0003, 32'h4040_0000, 33);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
